alu_acc_seq: RTL

Parametrised successor to the combinational 8-bit ALU. It adds an internal accumulator, a registered flag set (Z/N/C/V), and a START/BUSY/DONE handshake. It also provides an optional iterative shift-add multiplier. The block sits between the control unit (opcode and START) and the data bus (IN operand), and replaces the external ALU plus ACC register pair.

---
 rtl/alu_acc_seq.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_acc_seq.sv
// Accumulator ALU with registered Z/N/C/V flags and a START/BUSY/DONE handshake.
// Define ALU_ACC_MUL_EN to build the iterative shift-add multiplier (opcode 1101).
module alu_acc_seq #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OP_WIDTH   = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [OP_WIDTH-1:0]   OP,
  input  logic [DATA_WIDTH-1:0] IN,
  output logic [DATA_WIDTH-1:0] ACC,
  output logic [DATA_WIDTH-1:0] PROD_HI,
  output logic                  ZF,
  output logic                  NF,
  output logic                  CF,
  output logic                  VF,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int unsigned W   = DATA_WIDTH;
  localparam int unsigned MSB = DATA_WIDTH - 1;

  localparam logic [3:0] OpAdd = 4'h0;
  localparam logic [3:0] OpSub = 4'h1;
  localparam logic [3:0] OpInc = 4'h2;
  localparam logic [3:0] OpDec = 4'h3;
  localparam logic [3:0] OpAnd = 4'h4;
  localparam logic [3:0] OpOr  = 4'h5;
  localparam logic [3:0] OpXor = 4'h6;
  localparam logic [3:0] OpNot = 4'h7;
  localparam logic [3:0] OpShl = 4'h8;
  localparam logic [3:0] OpShr = 4'h9;
  localparam logic [3:0] OpLd  = 4'hA;
  localparam logic [3:0] OpCmp = 4'hB;
  localparam logic [3:0] OpAdc = 4'hC;
`ifdef ALU_ACC_MUL_EN
  localparam logic [3:0] OpMul = 4'hD;
`endif

  logic [W-1:0] acc_q;
  logic         zf_q, nf_q, cf_q, vf_q, done_q;
  logic [3:0]   op_lo;
  logic         op_hi_zero;
  logic         busy;
  logic         accept;

  assign op_lo = OP[3:0];

  // Opcodes with any bit set above the low nibble decode as NOP.
  if (OP_WIDTH > 4) begin : g_op_hi
    assign op_hi_zero = ~|OP[OP_WIDTH-1:4];
  end else begin : g_op_no_hi
    assign op_hi_zero = 1'b1;
  end

  assign accept = START & ~busy;

  logic [W-1:0] arith_b;
  logic [W:0]   sum;
  logic [W:0]   diff;
  logic         add_v, sub_v;

  assign arith_b = (op_lo == OpInc || op_lo == OpDec) ? {{(W-1){1'b0}}, 1'b1} : IN;
  assign sum     = {1'b0, acc_q} + {1'b0, arith_b} + {{W{1'b0}}, (op_lo == OpAdc) & cf_q};
  assign diff    = {1'b0, acc_q} - {1'b0, arith_b};
  assign add_v   = (acc_q[MSB] == arith_b[MSB]) & (sum[MSB] != acc_q[MSB]);
  assign sub_v   = (acc_q[MSB] != arith_b[MSB]) & (diff[MSB] != acc_q[MSB]);

  logic [W-1:0] res;
  logic         res_c, res_v, wr_acc, wr_flags;
`ifdef ALU_ACC_MUL_EN
  logic         mul_go;
`endif

  always_comb begin
    res      = acc_q;
    res_c    = 1'b0;
    res_v    = 1'b0;
    wr_acc   = 1'b0;
    wr_flags = 1'b0;
`ifdef ALU_ACC_MUL_EN
    mul_go   = 1'b0;
`endif
    if (op_hi_zero) begin
      case (op_lo)
        OpAdd, OpInc, OpAdc: begin
          res = sum[W-1:0]; res_c = sum[W]; res_v = add_v; wr_acc = 1'b1; wr_flags = 1'b1;
        end
        OpSub, OpDec: begin
          res = diff[W-1:0]; res_c = diff[W]; res_v = sub_v; wr_acc = 1'b1; wr_flags = 1'b1;
        end
        OpCmp: begin
          res = diff[W-1:0]; res_c = diff[W]; res_v = sub_v; wr_flags = 1'b1;
        end
        OpAnd: begin res = acc_q & IN; wr_acc = 1'b1; wr_flags = 1'b1; end
        OpOr:  begin res = acc_q | IN; wr_acc = 1'b1; wr_flags = 1'b1; end
        OpXor: begin res = acc_q ^ IN; wr_acc = 1'b1; wr_flags = 1'b1; end
        OpNot: begin res = ~acc_q;     wr_acc = 1'b1; wr_flags = 1'b1; end
        OpShl: begin
          res = {acc_q[W-2:0], 1'b0}; res_c = acc_q[MSB]; wr_acc = 1'b1; wr_flags = 1'b1;
        end
        OpShr: begin
          res = {1'b0, acc_q[W-1:1]}; res_c = acc_q[0]; wr_acc = 1'b1; wr_flags = 1'b1;
        end
        OpLd:  begin res = IN; wr_acc = 1'b1; wr_flags = 1'b1; end
`ifdef ALU_ACC_MUL_EN
        OpMul: mul_go = 1'b1;
`endif
        default: ;
      endcase
    end
  end

`ifdef ALU_ACC_MUL_EN
  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [W-1:0]    mcand_q;
  logic [2*W-1:0]  prod_q;
  logic [W-1:0]    prod_hi_q;
  logic [W:0]      step_sum;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept && mul_go) state_d = StMul;
      StMul:   if (cnt_q == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Low half of prod_q starts as the multiplier and is shifted out as the product shifts in.
  assign step_sum = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign busy     = (state_q == StMul);
  assign PROD_HI  = prod_hi_q;
`else
  assign busy     = 1'b0;
  assign PROD_HI  = '0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q     <= '0;
      zf_q      <= 1'b0;
      nf_q      <= 1'b0;
      cf_q      <= 1'b0;
      vf_q      <= 1'b0;
      done_q    <= 1'b0;
`ifdef ALU_ACC_MUL_EN
      cnt_q     <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
      prod_hi_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept) begin
`ifdef ALU_ACC_MUL_EN
        if (mul_go) begin
          mcand_q <= acc_q;
          prod_q  <= {{W{1'b0}}, IN};
          cnt_q   <= CntW'(W);
        end else
`endif
        begin
          done_q <= 1'b1;
          if (wr_acc) acc_q <= res;
          if (wr_flags) begin
            zf_q <= ~|res;
            nf_q <= res[MSB];
            cf_q <= res_c;
            vf_q <= res_v;
          end
        end
      end
`ifdef ALU_ACC_MUL_EN
      if (state_q == StMul) begin
        if (cnt_q == '0) begin
          acc_q     <= prod_q[W-1:0];
          prod_hi_q <= prod_q[2*W-1:W];
          zf_q      <= ~|prod_q[W-1:0];
          nf_q      <= prod_q[MSB];
          cf_q      <= |prod_q[2*W-1:W];
          vf_q      <= 1'b0;
          done_q    <= 1'b1;
        end else begin
          prod_q <= {step_sum, prod_q[W-1:1]};
          cnt_q  <= cnt_q - CntW'(1);
        end
      end
`endif
    end
  end

  assign ACC  = acc_q;
  assign ZF   = zf_q;
  assign NF   = nf_q;
  assign CF   = cf_q;
  assign VF   = vf_q;
  assign BUSY = busy;
  assign DONE = done_q;

endmodule
